// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: handshake bundle between a tile producer and the systolic feeder.
//   Weight channel: w_valid, w_ready, w_data. Element (r,c) sits at bit offset
//     (r*ARRAY_DIM+c)*WEIGHT_WIDTH.
//   Activation channel: a_valid, a_ready, a_data, a_last. Element r (array row r) sits at
//     offset r*DATA_WIDTH. a_last marks the final vector of a tile.
//   master: the producer side (drives valid/data/last, reads ready).
//   slave:  the feeder side (reads valid/data/last, drives ready).
interface systolic_feeder_if #(
  parameter int unsigned ARRAY_DIM    = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8
);
  logic                                        w_valid;
  logic                                        w_ready;
  logic [ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH-1:0] w_data;
  logic                                        a_valid;
  logic                                        a_ready;
  logic [ARRAY_DIM*DATA_WIDTH-1:0]             a_data;
  logic                                        a_last;

  modport master (
    output w_valid, w_data, a_valid, a_data, a_last,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, a_last,
    output w_ready, a_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts a weight tile and a stream of activation vectors and feeds a
// ARRAY_DIM x ARRAY_DIM systolic core. Activations are skewed so row r lags row 0 by r cycles.
//   clk, rst                 : single clock, asynchronous active-high reset.
//   bus (slave)              : weight and activation handshakes (see systolic_feeder_if).
//   core_weights_in_flat     : weight tile captured on the weight handshake.
//   load_weights_en_array    : one-cycle weight load strobe (LOAD state).
//   core_enable              : PE enable, high in STREAM and DRAIN.
//   core_activation_in_flat  : skewed activations, row r at offset r*DATA_WIDTH.
//   core_psum_in_flat        : top-row partial sums, tied to zero.
//   busy                     : high in every state except IDLE.
//   done                     : one-cycle pulse in the first IDLE cycle after DRAIN.
// Optional: define SYSTOLIC_FEEDER_STALL_CNT_EN to add stall_cnt, a saturating 16-bit count of
// STREAM cycles with a_valid low, cleared when a new weight tile is accepted.
module systolic_feeder #(
  parameter int unsigned ARRAY_DIM    = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACCUM_WIDTH  = 24
) (
  input  logic                                        clk,
  input  logic                                        rst,
  systolic_feeder_if.slave                            bus,
  output logic [ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH-1:0] core_weights_in_flat,
  output logic                                        load_weights_en_array,
  output logic                                        core_enable,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0]             core_activation_in_flat,
  output logic [ARRAY_DIM*ACCUM_WIDTH-1:0]            core_psum_in_flat,
  output logic                                        busy,
  output logic                                        done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                                 stall_cnt
`endif
);

  localparam int unsigned CntWidth = $clog2(2 * ARRAY_DIM);
  // DRAIN runs while the counter walks DrainLoad..0, i.e. 2*ARRAY_DIM-1 cycles.
  localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(2 * ARRAY_DIM - 2);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

  state_e                                      state_q, state_d;
  logic [CntWidth-1:0]                         drain_cnt_q, drain_cnt_d;
  logic                                        done_q;
  logic [ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH-1:0] weights_q;

  logic w_ready_s;
  logic a_ready_s;
  logic w_hs;
  logic a_hs;
  logic advance;

  assign w_ready_s = (state_q == StIdle);
  assign a_ready_s = (state_q == StStream);
  assign w_hs      = bus.w_valid && w_ready_s;
  assign a_hs      = bus.a_valid && a_ready_s;
  assign advance   = (state_q == StStream) || (state_q == StDrain);

  // Held low while rst is asserted so every output reads zero during reset.
  assign bus.w_ready = w_ready_s && !rst;
  assign bus.a_ready = a_ready_s;

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= (state_q == StDrain) && (drain_cnt_q == '0);
    end
  end

  always_comb begin
    state_d               = state_q;
    drain_cnt_d           = drain_cnt_q;
    load_weights_en_array = 1'b0;
    core_enable           = 1'b0;
    busy                  = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (w_hs) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_weights_en_array = 1'b1;
        state_d               = StStream;
      end
      StStream: begin
        core_enable = 1'b1;
        if (a_hs && bus.a_last) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end
      end
      StDrain: begin
        core_enable = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign done = done_q;

  // ---------------------------------------------------------------------------------------------
  // Weight tile register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights_q <= '0;
    end else if (w_hs) begin
      weights_q <= bus.w_data;
    end
  end

  assign core_weights_in_flat = weights_q;
  assign core_psum_in_flat    = '0;

  // ---------------------------------------------------------------------------------------------
  // Activation skew: row r is an (r+1)-deep shift register. Stage 0 captures on the handshake
  // edge, so row r presents its element r edges later. Cycles without a handshake push zero.
  // ---------------------------------------------------------------------------------------------
  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
    logic [DATA_WIDTH-1:0] line_q [r+1];
    logic [DATA_WIDTH-1:0] line_in;

    assign line_in = a_hs ? bus.a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          line_q[i] <= '0;
        end
      end else if (advance) begin
        line_q[0] <= line_in;
        for (int i = 1; i <= r; i++) begin
          line_q[i] <= line_q[i-1];
        end
      end
    end

    assign core_activation_in_flat[r*DATA_WIDTH +: DATA_WIDTH] = line_q[r];
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  // ---------------------------------------------------------------------------------------------
  // Stall counter: STREAM cycles starved of activations, saturating.
  // ---------------------------------------------------------------------------------------------
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (w_hs) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StStream) && !bus.a_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ARRAY_DIM, 4, array rows/columns.
- DATA_WIDTH, 16, activation width.
- WEIGHT_WIDTH, 8, weight width.
- ACCUM_WIDTH, 24, partial-sum width.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.

REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- w_valid  in  1  weight tile offered.
- w_ready  out  1  weight tile accepted when high with w_valid.
- w_data  in  ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH  weight tile, element (r,c) at bit offset (r*ARRAY_DIM+c)*WEIGHT_WIDTH.
- a_valid  in  1  activation vector offered.
- a_ready  out  1  activation vector accepted when high with a_valid.
- a_data  in  ARRAY_DIM*DATA_WIDTH  activation vector, element r for array row r at offset r*DATA_WIDTH.
- a_last  in  1  marks final vector of a tile, qualified by the a_valid&&a_ready handshake.
- core_weights_in_flat  out  ARRAY_DIM*ARRAY_DIM*WEIGHT_WIDTH  registered weight tile.
- load_weights_en_array  out  1  weight load strobe.
- core_enable  out  1  PE enable.
- core_activation_in_flat  out  ARRAY_DIM*DATA_WIDTH  skewed activations.
- core_psum_in_flat  out  ARRAY_DIM*ACCUM_WIDTH  top-row partial sums.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle tile-complete pulse.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD, STREAM and DRAIN.
REQ-005 In IDLE, w_ready SHALL be 1; a_ready SHALL be 1 only in STREAM.
REQ-006 On w_valid&&w_ready, w_data SHALL be registered into core_weights_in_flat and the FSM SHALL go to LOAD.
REQ-007 LOAD SHALL last exactly one cycle with load_weights_en_array=1, then go to STREAM; load_weights_en_array SHALL be 0 in all other states.
REQ-008 core_enable SHALL be 1 in STREAM and DRAIN and 0 in IDLE and LOAD.
REQ-009 Row r SHALL have a skew delay line of depth r+1 registers, giving a total latency of r+1 cycles from the input sample to core_activation_in_flat row r.
REQ-010 Element r of a vector accepted at clock edge E SHALL appear on row r after edge E+r and hold for exactly one cycle.
REQ-011 The skew lines SHALL advance every cycle in STREAM and DRAIN, and SHALL hold in IDLE and LOAD.
REQ-012 In every STREAM cycle without a handshake, and in every DRAIN cycle, the skew lines SHALL insert zero, producing a bubble.
REQ-013 A handshake with a_last=1 SHALL push that vector and move the FSM to DRAIN.
REQ-014 DRAIN SHALL last exactly 2*ARRAY_DIM-1 cycles, counted by a ceil(log2(2*ARRAY_DIM))-bit down-counter, then return to IDLE.
REQ-015 done SHALL be 1 for exactly the first IDLE cycle after DRAIN; a new weight handshake in that cycle SHALL be legal.
REQ-016 core_psum_in_flat SHALL be constant zero.
REQ-017 w_valid outside IDLE and a_valid outside STREAM SHALL be ignored and SHALL NOT change any state.
REQ-018 w_data and a_data SHALL only be sampled on their handshake edges.

Reset
REQ-019 Assertion of rst SHALL immediately force:
- state IDLE;
- all skew registers, core_weights_in_flat and the drain counter to 0;
- load_weights_en_array, core_enable, a_ready, busy and done to 0.
REQ-020 A reset during LOAD, STREAM or DRAIN SHALL abandon the tile with no done pulse.
REQ-021 After rst is released, w_ready SHALL be 1 from the first cycle.

Configuration
REQ-022 When SYSTOLIC_FEEDER_STALL_CNT_EN is defined:
- an extra output stall_cnt (out, 16 bits) SHALL count STREAM cycles with a_valid=0;
- stall_cnt SHALL saturate at 0xFFFF;
- stall_cnt SHALL clear to 0 on entry to LOAD and on reset.
REQ-023 When SYSTOLIC_FEEDER_STALL_CNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (ARRAY_DIM=4, DATA_WIDTH=16)
REQ-024 Weight handshake with w_data all 0x01:
- load_weights_en_array=1 for exactly one cycle, in the cycle after the handshake;
- STREAM is entered next, with a_ready=1.
REQ-025 Single vector with rows 0..3 = 0x0001, 0x0002, 0x0003, 0x0004 and a_last=1, accepted at edge E:
- row 0 = 0x0001 after E;
- row 1 = 0x0002 after E+1;
- row 2 = 0x0003 after E+2;
- row 3 = 0x0004 after E+3;
- all other row samples are 0;
- done=1 exactly 8 cycles after E.
REQ-026 Three back-to-back vectors 0x0011, 0x0022, 0x0033 (all rows) with one a_valid=0 bubble between the 2nd and 3rd vector:
- row 3 shows 0x0011, 0x0022, 0, 0x0033 on consecutive cycles, starting 3 cycles after row 0.
REQ-027 rst asserted mid-STREAM:
- all outputs are 0 and busy=0 before the next edge;
- no done pulse follows;
- w_ready=1 after release.
REQ-028 With SYSTOLIC_FEEDER_STALL_CNT_EN defined, 5 idle STREAM cycles then a last vector:
- stall_cnt=5;
- stall_cnt clears on the next LOAD.
